// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES-128 decryption controller.
// Accepts one ciphertext block, applies 11 round keys (one round per clock),
// fetching each key by index from an external expanded-key store, and
// presents the plaintext on a valid/ready output handshake.
module aes_inv_round_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RK  = 4'd10;
    localparam logic [RND_W-1:0] FIRST_RD = 4'd9;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    fsm_t             fsm;
    logic [RND_W-1:0] rnd;
    logic [BLK_W-1:0] state_reg;
    logic [BLK_W-1:0] sub_out;
    logic [BLK_W-1:0] ark_out;
    logic [BLK_W-1:0] mix_out;

    // Byte lookup: (255 - b) * 8 is simply {~b, 3'b000}.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return INV_SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r; byte index is r + 4*c (column-major).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return t;
    endfunction

    // One column of InvMixColumns using the {0e,0b,0d,09} circulant.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] a, x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a     = col[31 - 8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            t[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return t;
    endfunction

    // Inverse-round datapath: the final round taps ark_out, full rounds mix_out.
    assign sub_out  = inv_sub_bytes(inv_shift_rows(state_reg));
    assign ark_out  = sub_out ^ rk_data;
    assign mix_out  = inv_mix_columns(ark_out);
    assign out_data = state_reg;

    // Control FSM with registered handshake, key index and busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rk_idx    <= LAST_RK;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data ^ rk_data;
                        rnd       <= FIRST_RD;
                        rk_idx    <= FIRST_RD;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= mix_out;
                    rk_idx    <= rnd - 4'd1;
                    if (rnd == 4'd1) begin
                        fsm <= FINAL;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                FINAL: begin
                    state_reg <= ark_out;
                    out_valid <= 1'b1;
                    rk_idx    <= LAST_RK;
                    fsm       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: FIPS-197 C.1 vector, key-index trace,
// backpressure, ignored input while busy, mid-round reset and back-to-back blocks.
module tb_aes_inv_round_ctrl;

    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ONES    = {128{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk_mem [11];
    logic [7:0]   sbox   [256];
    logic [7:0]   isbox  [256];

    int n_cmp = 0;
    int n_bad = 0;

    aes_inv_round_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Expanded-key store with combinational same-cycle return.
    always_comb rk_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Generic GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] p, a, b;
        p = 8'h00;
        a = a_in;
        b = b_in;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_tables();
        logic [7:0] inv, s, xb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (xb != 8'h00 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = xb;
        end
    endtask

    task automatic expand_key();
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Reference AES-128 inverse cipher over a byte array.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = ct ^ rk_mem[10];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) s[i] = v[127 - 8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = isbox[s[row + 4*((c - row + 4) % 4)]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk_mem[r][127 - 8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
                    s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
                    s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
                    s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
        end
        return v;
    endfunction

    // Send one block from IDLE, check latency and plaintext, return to IDLE.
    task automatic run_one(input logic [127:0] ct, input logic [127:0] exp, input string tag);
        int lat;
        in_valid  = 1'b1;
        in_data   = ct;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd11);
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int acc [2];
        logic [127:0] outs [2];
        int n_acc, n_out;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        build_tables();
        expand_key();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd10);
        chk("rst_out_data", out_data, 128'd0);
        reset = 1'b0;

        // FIPS block with per-cycle key-index trace
        in_valid = 1'b1;
        in_data  = FIPS_CT;
        chk("acc_rk_idx", 128'(rk_idx), 128'd10);
        chk("acc_in_ready", 128'(in_ready), 128'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = '0;
            chk("trace_rk_idx", 128'(rk_idx), 128'(10 - k));
            chk("trace_busy", 128'(busy), 128'd1);
            chk("trace_out_valid", 128'(out_valid), 128'd0);
        end
        @(negedge clk);
        chk("fips_out_valid", 128'(out_valid), 128'd1);
        chk("fips_out_data", out_data, FIPS_PT);
        chk("done_rk_idx", 128'(rk_idx), 128'd10);
        chk("done_busy", 128'(busy), 128'd1);

        // Backpressure: output held while out_ready is low
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_data", out_data, FIPS_PT);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 128'(in_ready), 128'd1);
        chk("rel_out_valid", 128'(out_valid), 128'd0);
        chk("rel_busy", 128'(busy), 128'd0);
        out_ready = 1'b0;

        // Second block offered while busy is ignored until IDLE
        in_valid  = 1'b1;
        in_data   = FIPS_CT;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = ONES;
        repeat (10) @(negedge clk);
        chk("ign_out_valid", 128'(out_valid), 128'd1);
        chk("ign_out_data", out_data, FIPS_PT);
        chk("ign_in_ready_done", 128'(in_ready), 128'd0);
        @(negedge clk);
        chk("ign_in_ready_idle", 128'(in_ready), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ign_accept_rk_idx", 128'(rk_idx), 128'd9);
        chk("ign_accept_busy", 128'(busy), 128'd1);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        chk("ones_out_valid", 128'(out_valid), 128'd1);
        chk("ones_out_data", out_data, model_decrypt(ONES));
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse while rnd = 5
        in_valid = 1'b1;
        in_data  = FIPS_CT;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rk_idx", 128'(rk_idx), 128'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_out_data", out_data, 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
        run_one(FIPS_CT, FIPS_PT, "post_rst");

        // Back-to-back blocks with in_valid and out_ready held high
        acc   = '{0, 0};
        outs  = '{128'd0, 128'd0};
        n_acc = 0;
        n_out = 0;
        in_valid  = 1'b1;
        in_data   = FIPS_CT;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (n_acc == 1) in_data = '0;
            if (n_acc >= 2) in_valid = 1'b0;
            if (in_valid && in_ready && n_acc < 2) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            if (out_valid && out_ready && n_out < 2) begin
                outs[n_out] = out_data;
                n_out++;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 128'(n_acc), 128'd2);
        chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b_outputs", 128'(n_out), 128'd2);
        chk("b2b_first", outs[0], FIPS_PT);
        chk("b2b_zero", outs[1], model_decrypt(128'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
